wb_dbg_master: RTL and testbench

- Byte-stream-to-Wishbone debug bridge. It parses host command frames arriving from a UART byte interface and issues single 32-bit Wishbone classic cycles on a spare interconnect master port (m2).
- Returns read data or a status byte on the TX byte stream.
- Lets the host peek/poke bram, uart, timer and gpio space without CPU involvement.

---
 rtl/dbg_pkg.sv | 16 +
 rtl/dbg_tx_serializer.sv | 40 ++++
 rtl/wb_dbg_master.sv | 139 +++++++++++++
 tb/tb_wb_dbg_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared constants for the byte-stream Wishbone debug bridge: frame opcodes,
// response bytes and parser/bus FSM state encodings.
package dbg_pkg;

  localparam logic [7:0] DBG_OP_RD   = 8'h52;  // 'R'
  localparam logic [7:0] DBG_OP_WR   = 8'h57;  // 'W'
  localparam logic [7:0] DBG_RSP_OK  = 8'h2B;  // '+'
  localparam logic [7:0] DBG_RSP_ERR = 8'h21;  // '!'

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/dbg_tx_serializer.sv
// Response serializer: loads a 32-bit word with a length of 1 or 4 bytes and
// emits it MSB-first over a valid/ready byte handshake.
module dbg_tx_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_len4,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [1:0]  r_left;   // bytes remaining after the one presented
  logic        r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_left  <= i_len4 ? 2'd3 : 2'd0;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      r_shift <= {r_shift[23:0], 8'h00};
      if (r_left == 2'd0) r_valid <= 1'b0;
      else                r_left  <= r_left - 2'd1;
    end
  end

  assign o_tx_data  = r_shift[31:24];
  assign o_tx_valid = r_valid;
  assign o_done     = r_valid && i_tx_ready && (r_left == 2'd0);

endmodule

// File: rtl/wb_dbg_master.sv
// Byte-stream to Wishbone classic debug master: parses 'R'/'W' frames and
// runs one 32-bit bus cycle per frame. Optional macro DBG_RX_TIMEOUT_EN.
module wb_dbg_master
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RX_IDLE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy,
  output logic        overrun
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        r_state, w_state_nxt;
  logic              r_we, r_cyc, r_busy, r_overrun;
  logic [1:0]        r_cnt;
  logic [31:0]       r_adr, r_wdat, w_rsp_word;
  logic [WAIT_W-1:0] r_wait;
  logic              w_op_hit, w_last_byte, w_bus_end, w_rx_to, w_load, w_rsp_len4, w_tx_done;

  assign w_op_hit    = rx_valid && ((rx_data == DBG_OP_RD) || (rx_data == DBG_OP_WR));
  assign w_last_byte = rx_valid && (r_cnt == 2'd3);
  assign w_bus_end   = wb_err_i || wb_ack_i || (r_wait == WAIT_LAST);
  assign w_load      = (r_state == ST_BUS) && w_bus_end;

`ifdef DBG_RX_TIMEOUT_EN
  localparam int                IDLE_W    = $clog2(RX_IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_IDLE_CYCLES - 1);
  logic              w_in_frame;
  logic [IDLE_W-1:0] r_idle;

  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_rx_to    = w_in_frame && !rx_valid && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_idle <= '0;
    else if (rx_valid || !w_in_frame) r_idle <= '0;
    else                             r_idle <= r_idle + 1'b1;
  end
`else
  assign w_rx_to = 1'b0;
`endif

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_op_hit) w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_rx_to)           w_state_nxt = ST_IDLE;
               else if (w_last_byte) w_state_nxt = r_we ? ST_DATA : ST_BUS;
      ST_DATA: if (w_rx_to)           w_state_nxt = ST_IDLE;
               else if (w_last_byte) w_state_nxt = ST_BUS;
      ST_BUS:  if (w_bus_end) w_state_nxt = ST_RESP;
      ST_RESP: if (w_tx_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // err beats ack; timeout (neither) also reports '!'
  always_comb begin
    w_rsp_word = {DBG_RSP_ERR, 24'h0};
    w_rsp_len4 = 1'b0;
    if (!wb_err_i && wb_ack_i) begin
      if (r_we) begin
        w_rsp_word = {DBG_RSP_OK, 24'h0};
      end else begin
        w_rsp_word = wb_dat_i;
        w_rsp_len4 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_wait    <= '0;
      r_cyc     <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_cyc     <= (w_state_nxt == ST_BUS);
      r_overrun <= rx_valid && ((r_state == ST_BUS) || (r_state == ST_RESP));
      r_wait    <= (r_state == ST_BUS) ? r_wait + 1'b1 : '0;
      if ((r_state == ST_IDLE) && w_op_hit) begin
        r_we  <= (rx_data == DBG_OP_WR);
        r_cnt <= 2'd0;
      end
      if (rx_valid && ((r_state == ST_ADDR) || (r_state == ST_DATA))) r_cnt <= r_cnt + 2'd1;
      if (rx_valid && (r_state == ST_ADDR)) r_adr  <= {r_adr[23:0], rx_data};
      if (rx_valid && (r_state == ST_DATA)) r_wdat <= {r_wdat[23:0], rx_data};
    end
  end

  dbg_tx_serializer u_tx (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_word     (w_rsp_word),
    .i_len4     (w_rsp_len4),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_done     (w_tx_done)
  );

  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_wdat;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_sel_o = {4{r_cyc}};
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Scoreboard bench for wb_dbg_master: random frames against a frame-level
// reference model, with a slave model, tx back-pressure and reset/overrun cases.
`timescale 1ns/1ps
module tb_wb_dbg_master;

  localparam int TO  = 16;
  localparam int RXI = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic        busy, overrun;

  always #5 clk = ~clk;

  wb_dbg_master #(.TIMEOUT_CYCLES(TO), .RX_IDLE_CYCLES(RXI)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .overrun(overrun)
  );

  typedef enum int {SL_ACK, SL_ERR, SL_BOTH, SL_NONE} sl_mode_e;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx[$];
  bus_exp_t    exp_bus[$];
  int          ov_seen = 0, ov_exp = 0, cyc_rises = 0, tx_acc = 0;
  sl_mode_e    sl_mode = SL_NONE;
  int          sl_delay = 0;
  logic [31:0] sl_rdata = '0;
  bit          rdy_rand = 1'b1;
  bit          stall_arm = 1'b0;
  int          stall_target = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: answers after sl_delay cycles of cyc, or never for SL_NONE.
  initial begin : slave
    int n;
    n = 0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wb_dat_i = sl_rdata;
      if (wb_cyc_o && wb_stb_o) begin
        wb_ack_i = (n == sl_delay) && (sl_mode == SL_ACK || sl_mode == SL_BOTH);
        wb_err_i = (n == sl_delay) && (sl_mode == SL_ERR || sl_mode == SL_BOTH);
        n++;
      end else begin
        n = 0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    int stall_left;
    stall_left = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_arm && tx_acc == stall_target) begin
        stall_arm = 1'b0; stall_left = 5;
      end
      if (stall_left > 0) begin
        tx_ready = 1'b0; stall_left--;
      end else begin
        tx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops scoreboards when the DUT presents tx bytes or starts a bus cycle.
  initial begin : monitor
    logic [7:0]  held_data;
    bit          hold, in_cyc;
    int          cyc_cnt, cur_len;
    logic [69:0] snap;
    bus_exp_t    cur;
    hold = 1'b0; in_cyc = 1'b0; cyc_cnt = 0; cur_len = 0; held_data = '0; snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0; in_cyc = 1'b0; cyc_cnt = 0;
        continue;
      end
      if (hold) check("tx_hold", {tx_valid, tx_data}, {1'b1, held_data});
      if (tx_valid && tx_ready) begin
        tx_acc++;
        if (exp_tx.size() == 0) check("tx_unexpected", {1'b1, tx_data}, 0);
        else                    check("tx_byte", tx_data, exp_tx.pop_front());
      end
      hold      = tx_valid && !tx_ready;
      held_data = tx_data;
      if (overrun) ov_seen++;

      if (wb_cyc_o && !in_cyc) begin
        cyc_rises++;
        in_cyc  = 1'b1;
        cyc_cnt = 1;
        snap    = {wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o};
        check("bus_stb_sel", {wb_stb_o, wb_sel_o}, {1'b1, 4'hF});
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", wb_adr_o, ~wb_adr_o);
          cur_len = -1;
        end else begin
          cur = exp_bus.pop_front();
          cur_len = cur.len;
          check("bus_adr", wb_adr_o, cur.adr);
          check("bus_we", wb_we_o, cur.we);
          if (cur.we) check("bus_dat", wb_dat_o, cur.dat);
        end
      end else if (wb_cyc_o) begin
        cyc_cnt++;
        check("bus_stable", {wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o}, snap);
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        check("cyc_len", cyc_cnt, cur_len);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int gapmax);
    logic [7:0] bytes[$];
    bytes.push_back(we ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) bytes.push_back(adr[8*i +: 8]);
    if (we) for (int i = 3; i >= 0; i--) bytes.push_back(dat[8*i +: 8]);
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == bytes.size() - 1) begin
        check("cyc_before_last", wb_cyc_o, 1'b0);
        send_byte(bytes[i], 0);
      end else begin
        send_byte(bytes[i], $urandom_range(0, gapmax));
      end
    end
    check("cyc_after_last", wb_cyc_o, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin @(posedge clk); #1; n++; end
    check("busy_idle", {busy, tx_valid}, 0);
  endtask

  // Reference model: frame-level expectations for bus cycle and response bytes.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input sl_mode_e mode, input int delay, input logic [31:0] rdata,
                        input bit inject, input int gapmax);
    bus_exp_t e;
    sl_mode = mode; sl_delay = delay; sl_rdata = rdata;
    e.adr = adr; e.dat = dat; e.we = we;
    e.len = (mode == SL_NONE) ? TO : delay + 1;
    exp_bus.push_back(e);
    if (mode != SL_ACK)  exp_tx.push_back(8'h21);
    else if (we)         exp_tx.push_back(8'h2B);
    else for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
    send_frame(we, adr, dat, gapmax);
    if (inject) begin
      rx_data = 8'h52; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      ov_exp++;
    end
    wait_idle();
    check("overrun_cnt", ov_seen, ov_exp);
    check("tx_drained", exp_tx.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus_exp_t   e;
    logic [7:0] jb;
    int         rises0;
    logic       r_we_t;
    int         r_sel;
    sl_mode_e   r_mode;

    rx_valid = 1'b0; rx_data = '0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_a", {tx_data, tx_valid, wb_cyc_o, wb_stb_o, busy, overrun, wb_sel_o, wb_we_o}, 0);
    check("reset_outs_b", {wb_adr_o, wb_dat_o}, 0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    do_txn(1'b1, 32'h0000_7002, 32'hDEAD_BEEF, SL_ACK, 2, 32'h0, 1'b0, 0);

    rdy_rand = 1'b0; stall_target = tx_acc + 1; stall_arm = 1'b1;
    do_txn(1'b0, 32'h0000_0010, 32'h0, SL_ACK, 1, 32'h1234_5678, 1'b0, 0);
    rdy_rand = 1'b1;

    do_txn(1'b0, 32'hDEAD_0000, 32'h0, SL_NONE, 0, 32'h0, 1'b0, 1);
    do_txn(1'b1, 32'h0000_1000, 32'hCAFE_F00D, SL_BOTH, 1, 32'h0, 1'b0, 1);
    do_txn(1'b0, 32'h0000_2000, 32'h0, SL_ERR, 3, 32'hFFFF_0000, 1'b0, 1);

    rises0 = cyc_rises;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    for (int i = 0; i < 6; i++) begin
      do jb = 8'($urandom); while (jb == 8'h52 || jb == 8'h57);
      send_byte(jb, $urandom_range(0, 2));
    end
    repeat (3) begin @(posedge clk); #1; end
    check("junk_busy", busy, 1'b0);
    check("junk_overrun", ov_seen, ov_exp);
    check("junk_no_bus", cyc_rises, rises0);

    do_txn(1'b0, 32'h0000_0020, 32'h0, SL_ACK, 4, 32'hA5A5_5A5A, 1'b1, 1);
    do_txn(1'b1, 32'h0000_0024, 32'h0BAD_CAFE, SL_ACK, 0, 32'h0, 1'b1, 0);

    sl_mode = SL_NONE;
    e.adr = 32'h0000_0040; e.dat = '0; e.we = 1'b0; e.len = TO;
    exp_bus.push_back(e);
    send_frame(1'b0, 32'h0000_0040, 32'h0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("cyc_before_reset", wb_cyc_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("reset_async", {wb_cyc_o, wb_stb_o, tx_valid, busy, wb_sel_o}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    do_txn(1'b0, 32'h0000_0044, 32'h0, SL_ACK, 1, 32'h0102_0304, 1'b0, 0);

`ifdef DBG_RX_TIMEOUT_EN
    rises0 = cyc_rises;
    send_byte(8'h52, 0);
    send_byte(8'h00, 0);
    repeat (60) begin @(posedge clk); #1; end
    check("rxto_busy", busy, 1'b0);
    check("rxto_no_bus", cyc_rises, rises0);
    do_txn(1'b1, 32'h0000_0050, 32'h5555_AAAA, SL_ACK, 2, 32'h0, 1'b0, 1);
`endif

    for (int t = 0; t < 40; t++) begin
      r_we_t = 1'($urandom_range(0, 1));
      r_sel  = $urandom_range(0, 9);
      r_mode = (r_sel < 6) ? SL_ACK : (r_sel == 6) ? SL_ERR : (r_sel == 7) ? SL_BOTH : SL_NONE;
      do_txn(r_we_t, $urandom, $urandom, r_mode, $urandom_range(0, 5), $urandom,
             ($urandom_range(0, 3) == 0), 2);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("final_tx_queue", exp_tx.size(), 0);
    check("final_bus_queue", exp_bus.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
